// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Optional performance counters are built only when BTB_STATS_EN is defined.
module branch_target_buffer #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_en,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            lookup_hit,
  output logic            lookup_taken,
  output logic [PC_W-1:0] lookup_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic            inv_all,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_mispred
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX   = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WEAK_N = CTR_WEAK_T - CTR_W'(1);

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];
  logic [PC_W-1:0]   target_d [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];
  logic [CTR_W-1:0]  ctr_d    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  always_comb begin
    lookup_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lookup_taken  = lookup_hit && ctr_q[lk_idx][CTR_W-1];
    lookup_target = lookup_hit ? target_q[lk_idx] : '0;
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (inv_all) begin
      for (int i = 0; i < ENTRIES; i++) valid_d[i] = 1'b0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          target_d[up_idx] = upd_target;
          if (ctr_q[up_idx] != CTR_MAX) ctr_d[up_idx] = ctr_q[up_idx] + CTR_W'(1);
        end else if (ctr_q[up_idx] != '0) begin
          ctr_d[up_idx] = ctr_q[up_idx] - CTR_W'(1);
        end
      end else if (upd_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
        ctr_d[up_idx]    = CTR_WEAK_T;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WEAK_N;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_lookups_d = stat_lookups_q;
    stat_mispred_d = stat_mispred_q;
    if (lookup_en) stat_lookups_d = stat_lookups_q + 32'd1;
    if (upd_valid && (upd_pred_taken != upd_taken)) stat_mispred_d = stat_mispred_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_mispred = stat_mispred_q;
`else
  logic unused_stats;
  assign unused_stats = lookup_en ^ upd_pred_taken;
  assign stat_lookups = '0;
  assign stat_mispred = '0;
`endif

  // PC low bits and bits above the tag never take part in indexing or matching.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, upd_pc};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (default parameters).
module tb_branch_target_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        lookup_hit, lookup_taken;
  logic [31:0] lookup_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        inv_all;
  logic [31:0] stat_lookups, stat_mispred;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_target_buffer dut (
    .clk(clk), .rst(rst),
    .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .lookup_hit(lookup_hit), .lookup_taken(lookup_taken), .lookup_target(lookup_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .inv_all(inv_all),
    .stat_lookups(stat_lookups), .stat_mispred(stat_mispred)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt; upd_pred_taken = taken;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    look(32'h40);
    total++; if (lookup_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%0b exp=0", lookup_hit); end
    total++; if (lookup_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%0b exp=0", lookup_taken); end
    total++; if (lookup_target !== 32'h0) begin bad++; $display("FAIL reset_target got=%h exp=0", lookup_target); end
    total++; if (stat_lookups !== 32'd0) begin bad++; $display("FAIL reset_stat_lookups got=%0d exp=0", stat_lookups); end
    total++; if (stat_mispred !== 32'd0) begin bad++; $display("FAIL reset_stat_mispred got=%0d exp=0", stat_mispred); end
  endtask

  task automatic test_alloc();
    look(32'h104);
    upd_valid = 1'b1; upd_pc = 32'h104; upd_taken = 1'b1; upd_target = 32'h200; upd_pred_taken = 1'b0;
    #1;
    total++; if (lookup_hit !== 1'b0) begin bad++; $display("FAIL same_cycle_old got=%0b exp=0", lookup_hit); end
    tick();
    upd_valid = 1'b0;
    look(32'h104);
    total++; if (lookup_hit !== 1'b1) begin bad++; $display("FAIL alloc_hit got=%0b exp=1", lookup_hit); end
    total++; if (lookup_taken !== 1'b1) begin bad++; $display("FAIL alloc_taken got=%0b exp=1", lookup_taken); end
    total++; if (lookup_target !== 32'h200) begin bad++; $display("FAIL alloc_target got=%h exp=200", lookup_target); end
    look(32'hFFFF_0107);
    total++; if (lookup_hit !== 1'b1 || lookup_target !== 32'h200) begin bad++; $display("FAIL ignore_bits got=%0b/%h exp=1/200", lookup_hit, lookup_target); end
  endtask

  task automatic test_alias();
    look(32'h144);
    total++; if (lookup_hit !== 1'b0) begin bad++; $display("FAIL alias_pre got=%0b exp=0", lookup_hit); end
    do_update(32'h144, 1'b1, 32'h300);
    look(32'h104);
    total++; if (lookup_hit !== 1'b0) begin bad++; $display("FAIL alias_evict got=%0b exp=0", lookup_hit); end
    look(32'h144);
    total++; if (lookup_hit !== 1'b1 || lookup_target !== 32'h300) begin bad++; $display("FAIL alias_new got=%0b/%h exp=1/300", lookup_hit, lookup_target); end
  endtask

  task automatic test_no_alloc();
    do_update(32'h108, 1'b0, 32'h555);
    look(32'h108);
    total++; if (lookup_hit !== 1'b0) begin bad++; $display("FAIL no_alloc got=%0b exp=0", lookup_hit); end
    do_update(32'h184, 1'b0, 32'h555);
    look(32'h144);
    total++; if (lookup_hit !== 1'b1 || lookup_target !== 32'h300) begin bad++; $display("FAIL miss_nt_keeps got=%0b/%h exp=1/300", lookup_hit, lookup_target); end
  endtask

  task automatic test_saturation();
    do_update(32'h104, 1'b1, 32'h204);
    look(32'h104);
    total++; if (lookup_taken !== 1'b1 || lookup_target !== 32'h204) begin bad++; $display("FAIL sat_alloc got=%0b/%h exp=1/204", lookup_taken, lookup_target); end
    do_update(32'h104, 1'b0, 32'h999);
    look(32'h104);
    total++; if (lookup_taken !== 1'b0 || lookup_target !== 32'h204) begin bad++; $display("FAIL sat_nt1 got=%0b/%h exp=0/204", lookup_taken, lookup_target); end
    do_update(32'h104, 1'b0, 32'h999);
    do_update(32'h104, 1'b0, 32'h999);
    look(32'h104);
    total++; if (lookup_hit !== 1'b1 || lookup_taken !== 1'b0) begin bad++; $display("FAIL sat_low got=%0b/%0b exp=1/0", lookup_hit, lookup_taken); end
    do_update(32'h104, 1'b1, 32'h208);
    look(32'h104);
    total++; if (lookup_taken !== 1'b0 || lookup_target !== 32'h208) begin bad++; $display("FAIL sat_t1 got=%0b/%h exp=0/208", lookup_taken, lookup_target); end
    do_update(32'h104, 1'b1, 32'h208);
    look(32'h104);
    total++; if (lookup_taken !== 1'b1) begin bad++; $display("FAIL sat_t2 got=%0b exp=1", lookup_taken); end
    do_update(32'h104, 1'b1, 32'h208);
    do_update(32'h104, 1'b1, 32'h208);
    do_update(32'h104, 1'b0, 32'h208);
    look(32'h104);
    total++; if (lookup_taken !== 1'b1) begin bad++; $display("FAIL sat_high_nt1 got=%0b exp=1", lookup_taken); end
    do_update(32'h104, 1'b0, 32'h208);
    look(32'h104);
    total++; if (lookup_taken !== 1'b0) begin bad++; $display("FAIL sat_high_nt2 got=%0b exp=0", lookup_taken); end
  endtask

  task automatic test_inv_coincident();
    upd_valid = 1'b1; upd_pc = 32'h208; upd_taken = 1'b1; upd_target = 32'h400; inv_all = 1'b1;
    tick();
    upd_valid = 1'b0; inv_all = 1'b0;
    look(32'h104);
    total++; if (lookup_hit !== 1'b0) begin bad++; $display("FAIL inv_104 got=%0b exp=0", lookup_hit); end
    look(32'h208);
    total++; if (lookup_hit !== 1'b0) begin bad++; $display("FAIL inv_208 got=%0b exp=0", lookup_hit); end
    look(32'h144);
    total++; if (lookup_hit !== 1'b0) begin bad++; $display("FAIL inv_144 got=%0b exp=0", lookup_hit); end
  endtask

  task automatic test_reset_priority();
    do_update(32'h104, 1'b1, 32'h500);
    rst = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h144; upd_taken = 1'b1; upd_target = 32'h600;
    tick();
    rst = 1'b0; upd_valid = 1'b0;
    look(32'h104);
    total++; if (lookup_hit !== 1'b0 || lookup_target !== 32'h0) begin bad++; $display("FAIL rst_clears got=%0b/%h exp=0/0", lookup_hit, lookup_target); end
    look(32'h144);
    total++; if (lookup_hit !== 1'b0) begin bad++; $display("FAIL rst_prio got=%0b exp=0", lookup_hit); end
  endtask

  task automatic test_stats();
    logic [31:0] exp_l, exp_m;
    rst = 1'b1; tick(); rst = 1'b0;
    lookup_en = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_pred_taken = 1'b0; upd_target = 32'h20;
    tick();
    upd_pc = 32'h14; upd_taken = 1'b0; upd_pred_taken = 1'b0;
    tick();
    upd_pc = 32'h18; upd_taken = 1'b0; upd_pred_taken = 1'b1;
    inv_all = 1'b1;
    tick();
    upd_valid = 1'b0; inv_all = 1'b0;
    tick(); tick();
    lookup_en = 1'b0;
    tick();
`ifdef BTB_STATS_EN
    exp_l = 32'd5; exp_m = 32'd2;
`else
    exp_l = 32'd0; exp_m = 32'd0;
`endif
    total++; if (stat_lookups !== exp_l) begin bad++; $display("FAIL stat_lookups got=%0d exp=%0d", stat_lookups, exp_l); end
    total++; if (stat_mispred !== exp_m) begin bad++; $display("FAIL stat_mispred got=%0d exp=%0d", stat_mispred, exp_m); end
  endtask

  initial begin
    rst = 1'b1; lookup_en = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
    inv_all = 1'b0;
    test_reset();
    test_alloc();
    test_alias();
    test_no_alloc();
    test_saturation();
    test_inv_coincident();
    test_reset_priority();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
